// File: rtl/ysyx_22041752_ifetch_pkg.sv
// Shared definitions for the instruction-fetch bus bridge: bus widths,
// AXI response codes, the default AR protection bits and the FSM encoding.
package ysyx_22041752_ifetch_pkg;

  localparam int SRAM_ADDR_WD = 32;
  localparam int SRAM_DATA_WD = 64;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [2:0] AR_PROT_DEFAULT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // Picks the 32-bit instruction out of a 64-bit beat and zero-extends it.
  function automatic logic [63:0] select_word(input logic sel_hi, input logic [63:0] beat);
    return {32'h0, sel_hi ? beat[63:32] : beat[31:0]};
  endfunction

endpackage

// File: rtl/ysyx_22041752_resp_hold.sv
// Response holding register for the fetch bridge. Captures the selected
// instruction word at the R handshake (or a fault from the misalignment
// path), holds it for the IFU, and drops responses that a flush cancelled.
module ysyx_22041752_resp_hold
  import ysyx_22041752_ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept_i,
  input  logic        flush_i,
  input  logic        capture_i,
  input  logic        fault_i,
  input  logic        cancel_i,
  input  logic        sel_hi_i,
  input  logic [63:0] rdata_i,
  input  logic [1:0]  rresp_i,
  output logic        valid_o,
  output logic        err_o,
  output logic [63:0] rdata_o
);

  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;

  // Next response: a new request clears it, a beat or fault fills it unless
  // the fetch was flushed (now or earlier), and a bare flush clears it.
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (accept_i) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
    end else if (capture_i) begin
      if (cancel_i || flush_i) begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
      end else begin
        valid_d = 1'b1;
        err_d   = (rresp_i != AXI_RESP_OKAY);
        rdata_d = select_word(sel_hi_i, rdata_i);
      end
    end else if (fault_i) begin
      if (flush_i) begin
        valid_d = 1'b0;
        err_d   = 1'b0;
      end else begin
        valid_d = 1'b1;
        err_d   = 1'b1;
      end
      rdata_d = '0;
    end else if (flush_i) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
    end
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_22041752_ifetch_bridge.sv
// Fetch-side bridge between the IFU's single-outstanding SRAM-style port and
// a read-only AXI4-Lite master. One transaction in flight at a time; flushes
// mark the in-flight beat as cancelled rather than withdrawing AR.
module ysyx_22041752_ifetch_bridge
  import ysyx_22041752_ifetch_pkg::*;
#(
  parameter int         ADDR_W  = SRAM_ADDR_WD,
  parameter int         DATA_W  = SRAM_DATA_WD,
  parameter logic [2:0] AR_PROT = AR_PROT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_en_i,
  output logic              inst_ready_o,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_valid_o,
  output logic              inst_err_o,
  input  logic              flush_i,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic [2:0]        m_arprot_o,
  input  logic              m_rvalid_i,
  output logic              m_rready_o,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic [1:0]        m_rresp_i
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:2] addr_q, addr_d;
  logic              cancel_q, cancel_d;
  logic              accept;
  logic              r_handshake;
  logic              fault_done;

  assign inst_ready_o = (state_q == ST_IDLE) && !reset;
  assign accept       = inst_en_i && inst_ready_o;
  assign r_handshake  = (state_q == ST_DATA) && m_rvalid_i;
  assign fault_done   = (state_q == ST_FAULT);

  assign m_arvalid_o = (state_q == ST_ADDR);
  assign m_rready_o  = (state_q == ST_DATA);
  assign m_araddr_o  = {addr_q[ADDR_W-1:3], 3'b000};
  assign m_arprot_o  = AR_PROT;

  // Next-state logic: misaligned requests take the bus-free FAULT path, and a
  // flush during ADDR/DATA only marks the beat as cancelled.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cancel_d = cancel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = inst_addr_i[ADDR_W-1:2];
          state_d = (inst_addr_i[1:0] == 2'b00) ? ST_ADDR : ST_FAULT;
        end
      end
      ST_ADDR: begin
        if (flush_i) cancel_d = 1'b1;
        if (m_arready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (flush_i) cancel_d = 1'b1;
        if (m_rvalid_i) begin
          state_d  = ST_IDLE;
          cancel_d = 1'b0;
        end
      end
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, request address and cancel flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cancel_q <= cancel_d;
    end
  end

  ysyx_22041752_resp_hold u_resp_hold (
    .clk       (clk),
    .reset     (reset),
    .accept_i  (accept),
    .flush_i   (flush_i),
    .capture_i (r_handshake),
    .fault_i   (fault_done),
    .cancel_i  (cancel_q),
    .sel_hi_i  (addr_q[2]),
    .rdata_i   (m_rdata_i),
    .rresp_i   (m_rresp_i),
    .valid_o   (inst_valid_o),
    .err_o     (inst_err_o),
    .rdata_o   (inst_rdata_o)
  );

  // The slave may only present an R beat while the bridge is waiting for it.
  rvalid_only_in_data: assert property (@(posedge clk) disable iff (reset)
    m_rvalid_i |-> (state_q == ST_DATA));

endmodule

// File: tb/tb_ysyx_22041752_ifetch_bridge.sv
// Bench for the fetch bridge: an AXI read slave with programmable AR/R wait
// states, a scoreboard of expected IFU responses, and one task per scenario.
module tb_ysyx_22041752_ifetch_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_en_i;
  logic        inst_ready_o;
  logic [31:0] inst_addr_i;
  logic [63:0] inst_rdata_o;
  logic        inst_valid_o;
  logic        inst_err_o;
  logic        flush_i;
  logic        m_arvalid_o;
  logic        m_arready_i;
  logic [31:0] m_araddr_o;
  logic [2:0]  m_arprot_o;
  logic        m_rvalid_i;
  logic        m_rready_o;
  logic [63:0] m_rdata_i;
  logic [1:0]  m_rresp_i;

  always #5 clk = ~clk;

  ysyx_22041752_ifetch_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .inst_en_i    (inst_en_i),
    .inst_ready_o (inst_ready_o),
    .inst_addr_i  (inst_addr_i),
    .inst_rdata_o (inst_rdata_o),
    .inst_valid_o (inst_valid_o),
    .inst_err_o   (inst_err_o),
    .flush_i      (flush_i),
    .m_arvalid_o  (m_arvalid_o),
    .m_arready_i  (m_arready_i),
    .m_araddr_o   (m_araddr_o),
    .m_arprot_o   (m_arprot_o),
    .m_rvalid_i   (m_rvalid_i),
    .m_rready_o   (m_rready_o),
    .m_rdata_i    (m_rdata_i),
    .m_rresp_i    (m_rresp_i)
  );

  typedef struct {
    logic        err;
    logic [63:0] data;
  } resp_t;

  resp_t       expQ[$];
  int          passCount  = 0;
  int          totalCount = 0;
  int          arDelay    = 0;
  int          rDelay     = 0;
  logic [63:0] slvData    = '0;
  logic [1:0]  slvResp    = 2'b00;

  // Expected IFU response for a fetch of address a answered with beat d / resp r.
  function automatic resp_t model(input logic [31:0] a, input logic [63:0] d, input logic [1:0] r);
    resp_t x;
    if (a[1:0] != 2'b00) begin
      x.err  = 1'b1;
      x.data = 64'h0;
    end else begin
      x.err  = (r != 2'b00);
      x.data = {32'h0, a[2] ? d[63:32] : d[31:0]};
    end
    return x;
  endfunction

  // AXI read slave: raises arready after arDelay cycles of arvalid, then
  // rvalid after rDelay cycles of rready. Handshakes are sampled at negedge.
  initial begin
    bit arSeen, rSeen, rstSeen, pendingR;
    int arCnt, rCnt;
    m_arready_i = 1'b0;
    m_rvalid_i  = 1'b0;
    m_rdata_i   = '0;
    m_rresp_i   = 2'b00;
    pendingR = 0;
    arCnt = 0;
    rCnt = 0;
    forever begin
      @(negedge clk);
      rstSeen = reset;
      arSeen  = m_arvalid_o && m_arready_i;
      rSeen   = m_rvalid_i && m_rready_o;
      @(posedge clk);
      #1;
      if (rstSeen) begin
        m_arready_i = 1'b0;
        m_rvalid_i  = 1'b0;
        pendingR = 0;
        arCnt = 0;
        rCnt = 0;
      end else begin
        if (arSeen) begin
          m_arready_i = 1'b0;
          arCnt = 0;
          rCnt = 0;
          pendingR = 1;
        end else if (m_arvalid_o && !m_arready_i) begin
          if (arCnt >= arDelay) m_arready_i = 1'b1;
          else arCnt++;
        end
        if (rSeen) begin
          m_rvalid_i = 1'b0;
          pendingR = 0;
        end else if (pendingR && m_rready_o && !m_rvalid_i) begin
          if (rCnt >= rDelay) begin
            m_rvalid_i = 1'b1;
            m_rdata_i  = slvData;
            m_rresp_i  = slvResp;
          end else rCnt++;
        end
      end
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents a request until it is accepted (bounded), leaving us one cycle after accept.
  task automatic issue(input logic [31:0] addr, output bit accepted);
    accepted = 0;
    inst_en_i   = 1'b1;
    inst_addr_i = addr;
    for (int i = 0; i < 20 && !accepted; i++) begin
      accepted = inst_ready_o;
      tick();
    end
    inst_en_i = 1'b0;
  endtask

  // Counts cycles (accept cycle = 0) until inst_valid rises, noting the R handshake cycle.
  task automatic wait_valid(input int budget, output int cyc, output int rHsAt, output bit arSeen);
    cyc = -1;
    rHsAt = -1;
    arSeen = 0;
    for (int c = 1; c <= budget; c++) begin
      if (m_arvalid_o) arSeen = 1;
      if (inst_valid_o) begin
        cyc = c;
        break;
      end
      if (m_rvalid_i && m_rready_o) rHsAt = c;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst_en_i = 1'b0;
    inst_addr_i = '0;
    flush_i = 1'b0;
    tick();
    tick();
    totalCount++; if (inst_ready_o !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", inst_ready_o); else passCount++;
    totalCount++; if (m_arvalid_o !== 1'b0) $display("[TB] FAIL reset_arvalid: got %b expected 0", m_arvalid_o); else passCount++;
    totalCount++; if (m_rready_o !== 1'b0) $display("[TB] FAIL reset_rready: got %b expected 0", m_rready_o); else passCount++;
    totalCount++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid_o); else passCount++;
    totalCount++; if (inst_err_o !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", inst_err_o); else passCount++;
    totalCount++; if (inst_rdata_o !== 64'h0) $display("[TB] FAIL reset_rdata: got %h expected 0", inst_rdata_o); else passCount++;
    totalCount++; if (m_araddr_o !== 32'h0) $display("[TB] FAIL reset_araddr: got %h expected 0", m_araddr_o); else passCount++;
    totalCount++; if (m_arprot_o !== 3'b100) $display("[TB] FAIL arprot: got %b expected 100", m_arprot_o); else passCount++;
    reset = 1'b0;
    #1;
    totalCount++; if (inst_ready_o !== 1'b1) $display("[TB] FAIL ready_after_reset: got %b expected 1", inst_ready_o); else passCount++;
    tick();
  endtask

  task automatic test_aligned();
    bit ok, arSeen;
    int cyc, rHs;
    resp_t e;
    arDelay = 0; rDelay = 0;
    slvData = 64'h1111_2222_3333_4444; slvResp = 2'b00;
    issue(32'h8000_0004, ok);
    expQ.push_back(model(32'h8000_0004, slvData, slvResp));
    totalCount++; if (m_arvalid_o !== 1'b1) $display("[TB] FAIL aligned_arvalid: got %b expected 1", m_arvalid_o); else passCount++;
    totalCount++; if (m_araddr_o !== 32'h8000_0000) $display("[TB] FAIL aligned_araddr: got %h expected 80000000", m_araddr_o); else passCount++;
    totalCount++; if (inst_ready_o !== 1'b0) $display("[TB] FAIL aligned_busy: got %b expected 0", inst_ready_o); else passCount++;
    wait_valid(20, cyc, rHs, arSeen);
    totalCount++; if (cyc !== 3) $display("[TB] FAIL aligned_latency: got %0d expected 3", cyc); else passCount++;
    e = expQ.pop_front();
    totalCount++; if (inst_rdata_o !== e.data) $display("[TB] FAIL aligned_rdata: got %h expected %h", inst_rdata_o, e.data); else passCount++;
    totalCount++; if (inst_err_o !== e.err) $display("[TB] FAIL aligned_err: got %b expected %b", inst_err_o, e.err); else passCount++;
    tick();
    totalCount++; if (inst_valid_o !== 1'b1) $display("[TB] FAIL aligned_hold: got %b expected 1", inst_valid_o); else passCount++;
  endtask

  task automatic test_back_pressure();
    bit ok, arDone;
    int arViol, readyViol, arCount, rHsAt, validAt;
    resp_t e;
    arDelay = 4; rDelay = 3;
    slvData = 64'hAAAA_BBBB_CCCC_DDDD; slvResp = 2'b00;
    issue(32'h8000_0010, ok);
    expQ.push_back(model(32'h8000_0010, slvData, slvResp));
    arDone = 0; arViol = 0; readyViol = 0; arCount = 0; rHsAt = -1; validAt = -1;
    for (int c = 1; c <= 40 && validAt < 0; c++) begin
      if (inst_valid_o) validAt = c;
      else begin
        if (inst_ready_o) readyViol++;
        if (!arDone) begin
          if (!m_arvalid_o || m_araddr_o !== 32'h8000_0010) arViol++;
          else arCount++;
          if (m_arready_i) arDone = 1;
        end
        if (m_rvalid_i && m_rready_o) rHsAt = c;
        tick();
      end
    end
    totalCount++; if (arViol !== 0) $display("[TB] FAIL bp_ar_stable: got %0d bad cycles expected 0", arViol); else passCount++;
    totalCount++; if (arCount !== arDelay + 1) $display("[TB] FAIL bp_ar_cycles: got %0d expected %0d", arCount, arDelay + 1); else passCount++;
    totalCount++; if (readyViol !== 0) $display("[TB] FAIL bp_ready_low: got %0d bad cycles expected 0", readyViol); else passCount++;
    totalCount++; if (rHsAt < 0 || validAt !== rHsAt + 1) $display("[TB] FAIL bp_valid_after_r: got %0d expected %0d", validAt, rHsAt + 1); else passCount++;
    e = expQ.pop_front();
    totalCount++; if (inst_rdata_o !== e.data) $display("[TB] FAIL bp_rdata: got %h expected %h", inst_rdata_o, e.data); else passCount++;
  endtask

  task automatic test_flush_data();
    bit ok, rHs, validEver;
    int dc, rHsAt, readyAfter;
    arDelay = 0; rDelay = 3;
    slvData = 64'hDEAD_BEEF_0BAD_F00D; slvResp = 2'b00;
    issue(32'h8000_0008, ok);
    dc = -1; rHs = 0; validEver = 0; rHsAt = -1; readyAfter = -1;
    for (int c = 1; c <= 12; c++) begin
      if (inst_valid_o) validEver = 1;
      if (rHsAt > 0 && c == rHsAt + 1) readyAfter = int'(inst_ready_o);
      if (m_rvalid_i && m_rready_o) begin rHs = 1; rHsAt = c; end
      if (m_rready_o) dc++;
      flush_i = (m_rready_o && dc == rDelay - 1);
      tick();
    end
    flush_i = 1'b0;
    totalCount++; if (rHs !== 1'b1) $display("[TB] FAIL flush_r_consumed: got %b expected 1", rHs); else passCount++;
    totalCount++; if (validEver !== 1'b0) $display("[TB] FAIL flush_valid_low: got %b expected 0", validEver); else passCount++;
    totalCount++; if (readyAfter !== 1) $display("[TB] FAIL flush_ready_after: got %0d expected 1", readyAfter); else passCount++;
  endtask

  task automatic test_flush_new_idle();
    bit ok, arSeen;
    int cyc, rHs;
    resp_t e;
    arDelay = 0; rDelay = 0;
    slvData = 64'h0102_0304_0506_0708; slvResp = 2'b00;
    issue(32'h8000_0030, ok);
    expQ.push_back(model(32'h8000_0030, slvData, slvResp));
    wait_valid(20, cyc, rHs, arSeen);
    e = expQ.pop_front();
    totalCount++; if (inst_rdata_o !== e.data) $display("[TB] FAIL stale_rdata: got %h expected %h", inst_rdata_o, e.data); else passCount++;
    slvData = 64'h5555_6666_7777_8888;
    flush_i = 1'b1;
    inst_en_i = 1'b1;
    inst_addr_i = 32'h8000_001C;
    expQ.push_back(model(32'h8000_001C, slvData, slvResp));
    tick();
    flush_i = 1'b0;
    inst_en_i = 1'b0;
    totalCount++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL stale_cleared: got %b expected 0", inst_valid_o); else passCount++;
    totalCount++; if (m_arvalid_o !== 1'b1) $display("[TB] FAIL flush_new_accepted: got %b expected 1", m_arvalid_o); else passCount++;
    totalCount++; if (m_araddr_o !== 32'h8000_0018) $display("[TB] FAIL flush_new_araddr: got %h expected 80000018", m_araddr_o); else passCount++;
    wait_valid(20, cyc, rHs, arSeen);
    e = expQ.pop_front();
    totalCount++; if (cyc !== 3) $display("[TB] FAIL flush_new_latency: got %0d expected 3", cyc); else passCount++;
    totalCount++; if (inst_rdata_o !== e.data) $display("[TB] FAIL flush_new_rdata: got %h expected %h", inst_rdata_o, e.data); else passCount++;
  endtask

  task automatic test_bus_error();
    bit ok, arSeen;
    int cyc, rHs;
    resp_t e;
    arDelay = 1; rDelay = 2;
    slvData = 64'h0123_4567_89AB_CDEF; slvResp = 2'b10;
    issue(32'h8000_0020, ok);
    expQ.push_back(model(32'h8000_0020, slvData, slvResp));
    wait_valid(30, cyc, rHs, arSeen);
    e = expQ.pop_front();
    totalCount++; if (rHs < 0 || cyc !== rHs + 1) $display("[TB] FAIL err_latency: got %0d expected %0d", cyc, rHs + 1); else passCount++;
    totalCount++; if (inst_err_o !== e.err) $display("[TB] FAIL err_flag: got %b expected %b", inst_err_o, e.err); else passCount++;
    totalCount++; if (inst_rdata_o !== e.data) $display("[TB] FAIL err_rdata: got %h expected %h", inst_rdata_o, e.data); else passCount++;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    totalCount++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL idle_flush_valid: got %b expected 0", inst_valid_o); else passCount++;
    totalCount++; if (inst_err_o !== 1'b0) $display("[TB] FAIL idle_flush_err: got %b expected 0", inst_err_o); else passCount++;
    slvResp = 2'b00;
  endtask

  task automatic test_misaligned();
    bit ok, arSeen;
    int cyc, rHs;
    resp_t e;
    arDelay = 0; rDelay = 0;
    issue(32'h8000_0002, ok);
    expQ.push_back(model(32'h8000_0002, slvData, slvResp));
    wait_valid(10, cyc, rHs, arSeen);
    e = expQ.pop_front();
    totalCount++; if (cyc !== 2) $display("[TB] FAIL mis_latency: got %0d expected 2", cyc); else passCount++;
    totalCount++; if (arSeen !== 1'b0) $display("[TB] FAIL mis_no_bus: got %b expected 0", arSeen); else passCount++;
    totalCount++; if (inst_err_o !== e.err) $display("[TB] FAIL mis_err: got %b expected %b", inst_err_o, e.err); else passCount++;
    totalCount++; if (inst_rdata_o !== e.data) $display("[TB] FAIL mis_rdata: got %h expected %h", inst_rdata_o, e.data); else passCount++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    arDelay = 10; rDelay = 0;
    issue(32'h8000_0040, ok);
    tick();
    totalCount++; if (m_arvalid_o !== 1'b1) $display("[TB] FAIL mid_in_addr: got %b expected 1", m_arvalid_o); else passCount++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    totalCount++; if (m_arvalid_o !== 1'b0) $display("[TB] FAIL mid_arvalid: got %b expected 0", m_arvalid_o); else passCount++;
    totalCount++; if (inst_ready_o !== 1'b1) $display("[TB] FAIL mid_ready: got %b expected 1", inst_ready_o); else passCount++;
    totalCount++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL mid_valid: got %b expected 0", inst_valid_o); else passCount++;
    arDelay = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_back_pressure();
    test_flush_data();
    test_flush_new_idle();
    test_bus_error();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
